// File: rtl/rail_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : rail_frame_packer
//  Purpose  : Snapshots one set of rail ADC samples per sampleValid strobe and
//             serialises it as a byte frame to a UART transmitter:
//             A5 5A seq NUM_ADCS {hi,lo}*NUM_ADCS check.
//             Snapshots arriving while a frame is in flight are dropped and
//             counted in a saturating 8-bit counter.
//  Options  : RAIL_FRAMER_CRC_EN - when defined the check byte is CRC-8
//             (poly 0x07, init 0x00, MSB-first); otherwise it is the 8-bit
//             modular sum of frame bytes 2..FRAME_LEN-2.
//  Revision : 1.0 - initial release
// ============================================================================
module rail_frame_packer #(
  parameter int NUM_ADCS = 5,
  parameter int SAMPLE_W = 12
) (
  input  logic                         sclk,
  input  logic                         rstn,
  input  logic                         sampleValid,
  input  logic [NUM_ADCS*SAMPLE_W-1:0] sampleData,
  input  logic                         uartReady,
  output logic                         dataReady,
  output logic [7:0]                   outByte,
  output logic                         frameBusy,
  output logic [7:0]                   dropCount
);

  localparam int               FRAME_LEN   = 5 + 2 * NUM_ADCS;
  // Largest frame is 69 bytes, so a 7-bit index always suffices.
  localparam int               IDX_W       = 7;
  localparam int               CH_W        = IDX_W - 1;
  localparam logic [IDX_W-1:0] c_FRAME_LEN = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [7:0]       c_NUM_ADCS  = 8'(NUM_ADCS);
  localparam logic [7:0]       c_SYNC0     = 8'hA5;
  localparam logic [7:0]       c_SYNC1     = 8'h5A;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_SEND      = 2'd1,
    S_WAIT_LOW  = 2'd2,
    S_WAIT_HIGH = 2'd3
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic [NUM_ADCS*SAMPLE_W-1:0] r_samples;
  logic [IDX_W-1:0]             r_idx;
  logic [7:0]                   r_acc;
  logic [7:0]                   r_seq;
  logic [7:0]                   r_out;
  logic [7:0]                   r_drop;

  logic                         w_capture;
  logic                         w_strobe;
  logic                         w_frame_done;
  logic                         w_fold;
  logic [IDX_W-1:0]             w_rel;
  logic [15:0]                  w_sample16;
  logic [7:0]                   w_byte;

`ifdef RAIL_FRAMER_CRC_EN
  // CRC-8, poly 0x07, processed MSB-first one byte at a time.
  function automatic logic [7:0] f_fold(input logic [7:0] acc, input logic [7:0] b);
    logic [7:0] c;
    c = acc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction
`else
  // Plain 8-bit modular sum.
  function automatic logic [7:0] f_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  // Select the frame byte addressed by the current index.
  always_comb begin
    w_rel      = r_idx - IDX_W'(4);
    w_sample16 = '0;
    for (int k = 0; k < NUM_ADCS; k++) begin
      if (w_rel[IDX_W-1:1] == CH_W'(k)) begin
        w_sample16 = 16'(r_samples[k*SAMPLE_W +: SAMPLE_W]);
      end
    end
    if (r_idx == IDX_W'(0)) begin
      w_byte = c_SYNC0;
    end else if (r_idx == IDX_W'(1)) begin
      w_byte = c_SYNC1;
    end else if (r_idx == IDX_W'(2)) begin
      w_byte = r_seq;
    end else if (r_idx == IDX_W'(3)) begin
      w_byte = c_NUM_ADCS;
    end else if (r_idx == c_LAST_IDX) begin
      w_byte = r_acc;
    end else begin
      // Even offset from the first sample byte is the high byte.
      w_byte = w_rel[0] ? w_sample16[7:0] : w_sample16[15:8];
    end
    // Sync bytes and the check byte itself are excluded from the check.
    w_fold = (r_idx >= IDX_W'(2)) && (r_idx < c_LAST_IDX);
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_strobe     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sampleValid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (uartReady) begin
          w_strobe    = 1'b1;
          w_state_nxt = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        // Wait for the transmitter to take the byte before offering another.
        if (!uartReady) begin
          w_state_nxt = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (uartReady) begin
          if (r_idx < c_FRAME_LEN) begin
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt  = S_IDLE;
            w_frame_done = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Snapshot, byte index, check accumulator, sequence and drop counter.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_samples <= '0;
      r_idx     <= '0;
      r_acc     <= 8'h00;
      r_seq     <= 8'h00;
      r_out     <= 8'h00;
      r_drop    <= 8'h00;
    end else begin
      if (w_capture) begin
        r_samples <= sampleData;
        r_idx     <= '0;
        r_acc     <= 8'h00;
      end
      if (w_strobe) begin
        r_out <= w_byte;
        r_idx <= r_idx + IDX_W'(1);
        if (w_fold) begin
          r_acc <= f_fold(r_acc, w_byte);
        end
      end
      if (w_frame_done) begin
        r_seq <= r_seq + 8'd1;
      end
      if (sampleValid && (r_state != S_IDLE) && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  // The strobe cycle shows the new byte directly so the first byte leaves one
  // cycle after capture; r_out holds it until the next strobe.
  assign dataReady = w_strobe;
  assign outByte   = w_strobe ? w_byte : r_out;
  assign frameBusy = (r_state != S_IDLE);
  assign dropCount = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_rail_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rail_frame_packer
//  Purpose  : Directed self-checking bench for rail_frame_packer with a
//             simple UART transmitter handshake model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rail_frame_packer;

  localparam int NUM_ADCS = 5;
  localparam int SAMPLE_W = 12;
  localparam int DW       = NUM_ADCS * SAMPLE_W;

  logic          sclk;
  logic          rstn;
  logic          sampleValid;
  logic [DW-1:0] sampleData;
  logic          uartReady;
  logic          dataReady;
  logic [7:0]    outByte;
  logic          frameBusy;
  logic [7:0]    dropCount;

  int errors;
  int checks;

  logic [7:0] got [0:127];
  int         got_n;
  int         first_wait;

  logic [DW-1:0] c_basic_data;
  logic [DW-1:0] c_alt_data;
  logic [7:0]    exp_basic [0:14];

  rail_frame_packer #(
    .NUM_ADCS (NUM_ADCS),
    .SAMPLE_W (SAMPLE_W)
  ) dut (
    .sclk        (sclk),
    .rstn        (rstn),
    .sampleValid (sampleValid),
    .sampleData  (sampleData),
    .uartReady   (uartReady),
    .dataReady   (dataReady),
    .outByte     (outByte),
    .frameBusy   (frameBusy),
    .dropCount   (dropCount)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Reference CRC-8 (poly 0x07, init 0, MSB-first).
  function automatic logic [7:0] ref_crc8(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ 8'h07;
      else      c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  task automatic do_reset();
    rstn        = 1'b0;
    sampleValid = 1'b0;
    uartReady   = 1'b1;
    repeat (2) @(posedge sclk);
    #1 rstn = 1'b1;
  endtask

  // One-cycle sampleValid pulse; on return the DUT has taken the capture edge.
  task automatic start_frame(input logic [DW-1:0] d);
    @(posedge sclk);
    #1;
    sampleValid = 1'b1;
    sampleData  = d;
    @(posedge sclk);
    #1 sampleValid = 1'b0;
  endtask

  // Transmitter model: accept nbytes strobes, dropping uartReady for one cycle
  // after each. Optional sampleValid pulses during the low phase of the first
  // 'pulses' bytes, and one coinciding with the WAIT_HIGH->IDLE step.
  task automatic tx_collect(input int nbytes, input int pulses, input bit last_pulse,
                            input bit final_high, input logic [DW-1:0] pdata);
    for (int b = 0; b < nbytes; b++) begin
      int  w;
      bit  seen;
      w    = 0;
      seen = 1'b0;
      while (!seen && w < 50) begin
        @(negedge sclk);
        w++;
        if (dataReady === 1'b1) begin
          seen       = 1'b1;
          got[got_n] = outByte;
          got_n++;
        end
      end
      if (b == 0) first_wait = w;
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL tx_timeout: byte %0d got no dataReady in 50 cycles, required one strobe", b);
        return;
      end
      @(posedge sclk);
      #1;
      uartReady = 1'b0;
      if (b < pulses) begin
        sampleValid = 1'b1;
        sampleData  = pdata;
      end
      @(posedge sclk);
      #1;
      sampleValid = 1'b0;
      if (!(b == nbytes - 1 && !final_high)) uartReady = 1'b1;
      if (b == nbytes - 1 && last_pulse) begin
        sampleValid = 1'b1;
        sampleData  = pdata;
      end
    end
    @(posedge sclk);
    #1 sampleValid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    checks++;
    if (dataReady !== 1'b0) begin errors++; $display("FAIL rst_dataReady: got %b want 0", dataReady); end
    checks++;
    if (outByte !== 8'h00) begin errors++; $display("FAIL rst_outByte: got %h want 00", outByte); end
    checks++;
    if (frameBusy !== 1'b0) begin errors++; $display("FAIL rst_frameBusy: got %b want 0", frameBusy); end
    checks++;
    if (dropCount !== 8'h00) begin errors++; $display("FAIL rst_dropCount: got %h want 00", dropCount); end
    do_reset();
  endtask

  task automatic test_basic_frame();
    int extra;
    do_reset();
    got_n = 0;
    start_frame(c_basic_data);
    checks++;
    if (frameBusy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b want 1", frameBusy); end
    tx_collect(15, 0, 1'b0, 1'b1, c_alt_data);
    checks++;
    if (first_wait !== 1) begin errors++; $display("FAIL first_latency: got %0d cycles want 1", first_wait); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp_basic[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h want %h", i, got[i], exp_basic[i]);
      end
    end
    checks++;
    if (got_n !== 15) begin errors++; $display("FAIL basic_count: got %0d want 15", got_n); end
    checks++;
    if (frameBusy !== 1'b0) begin errors++; $display("FAIL basic_busy_fall: got %b want 0", frameBusy); end
    extra = 0;
    repeat (5) begin
      @(negedge sclk);
      if (dataReady === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL basic_extra_strobes: got %0d want 0", extra); end
  endtask

  task automatic test_overrun();
    do_reset();
    got_n = 0;
    start_frame(c_basic_data);
    tx_collect(14, 3, 1'b0, 1'b1, c_alt_data);
    checks++;
    if (dropCount !== 8'd3) begin errors++; $display("FAIL overrun_drop3: got %0d want 3", dropCount); end
    tx_collect(1, 0, 1'b1, 1'b1, c_alt_data);
    checks++;
    if (dropCount !== 8'd4) begin errors++; $display("FAIL overrun_drop4: got %0d want 4", dropCount); end
    checks++;
    if (frameBusy !== 1'b0) begin errors++; $display("FAIL overrun_idle: got busy %b want 0", frameBusy); end
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp_basic[i]) begin
        errors++;
        $display("FAIL overrun_byte%0d: got %h want %h", i, got[i], exp_basic[i]);
      end
    end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int f = 1; f <= 257; f++) begin
      got_n = 0;
      start_frame(c_basic_data);
      tx_collect(15, 0, 1'b0, 1'b1, c_alt_data);
      if (f == 2) begin
        checks++;
        if (got[2] !== 8'h01) begin errors++; $display("FAIL seq_frame2: got %h want 01", got[2]); end
      end
      if (f == 256) begin
        checks++;
        if (got[2] !== 8'hFF) begin errors++; $display("FAIL seq_frame256: got %h want ff", got[2]); end
      end
      if (f == 257) begin
        checks++;
        if (got[2] !== 8'h00) begin errors++; $display("FAIL seq_frame257: got %h want 00", got[2]); end
        checks++;
        if (got[14] !== exp_basic[14]) begin errors++; $display("FAIL seq_frame257_check: got %h want %h", got[14], exp_basic[14]); end
      end
    end
  endtask

  task automatic test_ready_high_saturation();
    int strobes;
    do_reset();
    start_frame(c_basic_data);
    strobes = 0;
    repeat (20) begin
      @(negedge sclk);
      if (dataReady === 1'b1) strobes++;
    end
    checks++;
    if (strobes !== 1) begin errors++; $display("FAIL held_high_strobes: got %0d want 1", strobes); end
    checks++;
    if (frameBusy !== 1'b1) begin errors++; $display("FAIL held_high_busy: got %b want 1", frameBusy); end
    for (int i = 0; i <= 300; i++) begin
      @(posedge sclk);
      #1;
      if (i == 254) begin
        checks++;
        if (dropCount !== 8'hFE) begin errors++; $display("FAIL drop_254: got %h want fe", dropCount); end
      end
      sampleValid = (i < 300);
      sampleData  = c_alt_data;
    end
    checks++;
    if (dropCount !== 8'hFF) begin errors++; $display("FAIL drop_saturate: got %h want ff", dropCount); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    got_n = 0;
    start_frame(c_basic_data);
    tx_collect(15, 0, 1'b0, 1'b1, c_alt_data);
    got_n = 0;
    start_frame(c_basic_data);
    tx_collect(7, 1, 1'b0, 1'b0, c_alt_data);
    checks++;
    if (outByte !== 8'h04) begin errors++; $display("FAIL mid_pre_outByte: got %h want 04", outByte); end
    checks++;
    if (dropCount !== 8'd1) begin errors++; $display("FAIL mid_pre_drop: got %h want 01", dropCount); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (dataReady !== 1'b0) begin errors++; $display("FAIL mid_rst_dataReady: got %b want 0", dataReady); end
    checks++;
    if (outByte !== 8'h00) begin errors++; $display("FAIL mid_rst_outByte: got %h want 00", outByte); end
    checks++;
    if (frameBusy !== 1'b0) begin errors++; $display("FAIL mid_rst_frameBusy: got %b want 0", frameBusy); end
    checks++;
    if (dropCount !== 8'h00) begin errors++; $display("FAIL mid_rst_dropCount: got %h want 00", dropCount); end
    @(posedge sclk);
    #1;
    rstn      = 1'b1;
    uartReady = 1'b1;
    got_n     = 0;
    start_frame(c_basic_data);
    tx_collect(15, 0, 1'b0, 1'b1, c_alt_data);
    for (int i = 0; i < 15; i++) begin
      checks++;
      if (got[i] !== exp_basic[i]) begin
        errors++;
        $display("FAIL mid_next_byte%0d: got %h want %h", i, got[i], exp_basic[i]);
      end
    end
  endtask

  initial begin
    logic [7:0] crc;
    errors       = 0;
    checks       = 0;
    got_n        = 0;
    first_wait   = 0;
    rstn         = 1'b0;
    sampleValid  = 1'b0;
    uartReady    = 1'b1;
    c_basic_data = {12'hDEF, 12'hABC, 12'h789, 12'h456, 12'h123};
    c_alt_data   = {DW{1'b1}};
    sampleData   = '0;
    exp_basic    = '{8'hA5, 8'h5A, 8'h00, 8'h05, 8'h01, 8'h23, 8'h04, 8'h56,
                     8'h07, 8'h89, 8'h0A, 8'hBC, 8'h0D, 8'hEF, 8'hD5};
`ifdef RAIL_FRAMER_CRC_EN
    crc = 8'h00;
    for (int i = 2; i <= 13; i++) crc = ref_crc8(crc, exp_basic[i]);
    exp_basic[14] = crc;
`else
    crc = ref_crc8(8'h00, 8'h00);
`endif

    test_reset();
    test_basic_frame();
    test_overrun();
    test_seq_wrap();
    test_ready_high_saturation();
    test_mid_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rail_frame_packer.md
# rail_frame_packer

Framing stage between the rail-sensing ADC block and the UART transmitter. It snapshots one set of rail samples per `sampleValid` strobe and serialises it into a fixed-length byte frame: sync word, sequence number, channel count, big-endian samples and a trailing check byte. The frame is fed to the UART transmitter through its start/data/ready handshake, and samples that arrive while a frame is in flight are dropped and counted.

## Interface
- `NUM_ADCS`, default 5: number of rail channels per snapshot (1–32).
- `SAMPLE_W`, default 12: bits per sample (1–16); zero-extended to 16 bits on the wire.
- `sclk`, in, 1: system clock; all logic is on its rising edge.
- `rstn`, in, 1: reset; one clock, asynchronous assert, active-low.
- `sampleValid`, in, 1: single-cycle strobe; `sampleData` is valid in the same cycle.
- `sampleData`, in, `NUM_ADCS*SAMPLE_W`: channel 0 sits in the LSBs.
- `uartReady`, in, 1: the transmitter can accept a byte.
- `dataReady`, out, 1: single-cycle start strobe to the transmitter.
- `outByte`, out, 8: byte to transmit; held stable from the strobe until the next strobe.
- `frameBusy`, out, 1: high from sample capture until the final byte is acknowledged.
- `dropCount`, out, 8: saturating count of dropped snapshots.

## Operation
- Frame layout (FRAME_LEN = 5 + 2·NUM_ADCS bytes):
  - bytes 0–1: sync bytes 0xA5, 0x5A.
  - byte 2: `seq`.
  - byte 3: `NUM_ADCS`.
  - samples, channel 0 first, high byte then low byte.
  - final byte: check byte.
- Check byte: 8-bit modular sum of frame bytes 2 through FRAME_LEN−2.
- States: IDLE, SEND, WAIT_LOW, WAIT_HIGH.
- IDLE:
  - On `sampleValid`, register all of `sampleData`, clear the byte index and check accumulator, then go to SEND.
- SEND:
  - When `uartReady` = 1: drive `outByte` with the indexed byte and pulse `dataReady` for one cycle.
  - In the same cycle, fold the byte into the check accumulator if its index is 2..FRAME_LEN−2.
  - Increment the index and go to WAIT_LOW.
- WAIT_LOW: go to WAIT_HIGH once `uartReady` = 0.
- WAIT_HIGH: once `uartReady` = 1, go to SEND if index < FRAME_LEN; otherwise go to IDLE.
- On return to IDLE: `seq` increments, wrapping 0xFF→0x00, and `frameBusy` falls.
- Drops:
  - `sampleValid` in any state other than IDLE drops the sample.
  - A drop increments `dropCount`, which saturates at 0xFF with no wrap.
  - A dropped sample does not disturb the frame in flight.
- A `sampleValid` arriving in the same cycle as the WAIT_HIGH→IDLE transition is dropped; snapshots are accepted only while in IDLE.
- Reset at any point aborts the frame; no partial-frame recovery is attempted.

## Timing
- Reset values:
  - `dataReady` 0, `outByte` 0x00, `frameBusy` 0, `dropCount` 0x00.
  - `seq` 0x00, state IDLE.
- Capture-to-first-strobe latency: `sampleValid` at cycle N gives the 0xA5 strobe at N+1 if `uartReady` is high at N+1.
- Only one `dataReady` strobe is issued per low→high cycle of `uartReady`, so a held-high `uartReady` never produces a second strobe.
- `frameBusy` rises at N+1 and falls in the cycle the state returns to IDLE.
- With `uartReady` stuck high after a strobe, the block waits in WAIT_LOW indefinitely; there is no timeout.

## Configuration
- `RAIL_FRAMER_CRC_EN`:
  - Defined: the check byte is CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR), computed MSB-first over the same bytes as the sum.
  - Undefined: the 8-bit modular sum is used.
  - Frame length and all timing are identical in both builds.

## Test plan
- **Basic frame** (NUM_ADCS=5, SAMPLE_W=12): samples 0x123, 0x456, 0x789, 0xABC, 0xDEF with a transmitter model.
  - Required bytes: A5 5A 00 05 01 23 04 56 07 89 0A BC 0D EF D5.
  - Exactly 15 strobes, then `frameBusy` = 0.
- **CRC build**: same stimulus with `RAIL_FRAMER_CRC_EN` defined; the final byte equals the reference-model CRC-8 of bytes 2–13, and bytes 0–13 are unchanged.
- **Overrun**: three `sampleValid` pulses during a frame; `dropCount` = 3 and the frame contents are unchanged.
  - A fourth pulse coinciding with the return to IDLE is also dropped, giving `dropCount` = 4.
- **Wraparound and saturation**:
  - 257 back-to-back frames: the seq byte of frame 257 is 0x00.
  - 300 drops: `dropCount` holds at 0xFF.
- **Ready held high**: `uartReady` tied high after the first strobe; exactly one `dataReady` is issued and the block stays in WAIT_LOW.
- **Mid-frame reset**: assert `rstn` = 0 after byte 6; all outputs return to reset values the same cycle, and the next frame starts with seq 0x00.
